// File: rtl/gf2m_inner_prod.sv
// GF(2^m) inner-product sequencer: streams operand pairs into a digit-serial multiplier and XOR-accumulates products.
// Optional one-entry operand prefetch when GF2M_IP_PREFETCH_EN is defined.
module gf2m_inner_prod #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   w_b_nxt;
    logic               r_in_ready;
    logic               w_ready_nxt;
    logic               r_mul_start;
    logic               w_mul_start_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_hs;
    logic               w_last;

`ifdef GF2M_IP_PREFETCH_EN
    // Prefetch entry plus a count of pairs accepted so far (caps intake at len).
    logic [WIDTH-1:0]   r_pf_a;
    logic [WIDTH-1:0]   w_pf_a_nxt;
    logic [WIDTH-1:0]   r_pf_b;
    logic [WIDTH-1:0]   w_pf_b_nxt;
    logic               r_pf_full;
    logic               w_pf_full_nxt;
    logic [LEN_W-1:0]   r_taken;
    logic [LEN_W-1:0]   w_taken_nxt;
`endif

    assign w_hs   = in_valid & r_in_ready;
    assign w_last = (r_cnt == (r_len - LEN_W'(1)));

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_a_nxt     = r_mul_a;
        w_b_nxt     = r_mul_b;
`ifdef GF2M_IP_PREFETCH_EN
        w_pf_a_nxt    = r_pf_a;
        w_pf_b_nxt    = r_pf_b;
        w_pf_full_nxt = r_pf_full;
        w_taken_nxt   = r_taken;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt   = len;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
`ifdef GF2M_IP_PREFETCH_EN
                    w_taken_nxt   = '0;
                    w_pf_full_nxt = 1'b0;
`endif
                    w_state_nxt = (len == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_hs) begin
                    w_a_nxt     = in_a;
                    w_b_nxt     = in_b;
`ifdef GF2M_IP_PREFETCH_EN
                    w_taken_nxt = r_taken + LEN_W'(1);
`endif
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
`ifdef GF2M_IP_PREFETCH_EN
                if (w_hs) begin
                    w_pf_a_nxt    = in_a;
                    w_pf_b_nxt    = in_b;
                    w_pf_full_nxt = 1'b1;
                    w_taken_nxt   = r_taken + LEN_W'(1);
                end
`endif
            end
            S_WAIT: begin
                if (mul_done) begin
                    w_acc_nxt = r_acc ^ mul_c;
                    w_cnt_nxt = r_cnt + LEN_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
`ifdef GF2M_IP_PREFETCH_EN
                        // A pair arriving together with mul_done bypasses the entry.
                        if (r_pf_full) begin
                            w_a_nxt       = r_pf_a;
                            w_b_nxt       = r_pf_b;
                            w_pf_full_nxt = 1'b0;
                            w_state_nxt   = S_ISSUE;
                        end else if (w_hs) begin
                            w_a_nxt     = in_a;
                            w_b_nxt     = in_b;
                            w_taken_nxt = r_taken + LEN_W'(1);
                            w_state_nxt = S_ISSUE;
                        end else begin
                            w_state_nxt = S_FETCH;
                        end
`else
                        w_state_nxt = S_FETCH;
`endif
                    end
                end
`ifdef GF2M_IP_PREFETCH_EN
                else if (w_hs) begin
                    w_pf_a_nxt    = in_a;
                    w_pf_b_nxt    = in_b;
                    w_pf_full_nxt = 1'b1;
                    w_taken_nxt   = r_taken + LEN_W'(1);
                end
`endif
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_FIN);
        w_mul_start_nxt = (w_state_nxt == S_ISSUE);
`ifdef GF2M_IP_PREFETCH_EN
        w_ready_nxt = (w_state_nxt == S_FETCH) |
                      (((w_state_nxt == S_ISSUE) | (w_state_nxt == S_WAIT)) &
                       ~w_pf_full_nxt & (w_taken_nxt < w_len_nxt));
`else
        w_ready_nxt = (w_state_nxt == S_FETCH);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_in_ready  <= 1'b0;
            r_mul_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef GF2M_IP_PREFETCH_EN
            r_pf_a      <= '0;
            r_pf_b      <= '0;
            r_pf_full   <= 1'b0;
            r_taken     <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_mul_a     <= w_a_nxt;
            r_mul_b     <= w_b_nxt;
            r_in_ready  <= w_ready_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef GF2M_IP_PREFETCH_EN
            r_pf_a      <= w_pf_a_nxt;
            r_pf_b      <= w_pf_b_nxt;
            r_pf_full   <= w_pf_full_nxt;
            r_taken     <= w_taken_nxt;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign acc_out   = r_acc;

endmodule

// File: tb/tb_gf2m_inner_prod.sv
// Testbench for gf2m_inner_prod: multiplier stub (XOR or true GF(2^67) product), vector table plus random streams.
module tb_gf2m_inner_prod;
    localparam int unsigned W  = 67;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_done;
    logic [W-1:0]  mul_c;
    logic          busy;
    logic          done;
    logic [W-1:0]  acc_out;

    logic          stub_done = 1'b0;
    logic [W-1:0]  stub_c = '0;
    logic          inj = 1'b0;
    logic [W-1:0]  inj_c = '0;
    int            stub_lat = 5;
    bit            use_gf = 1'b0;
    int            st_cnt = 0;
    logic [W-1:0]  st_a = '0;
    logic [W-1:0]  st_b = '0;
    bit            st_dirty = 1'b0;
    int            n_mstart = 0;
    int            n_sdone = 0;
    int            stab_bad = 0;

    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  pa[256];
    logic [W-1:0]  pb[256];

    assign mul_done = stub_done | inj;
    assign mul_c    = inj ? inj_c : stub_c;

    always #5 clk = ~clk;

    gf2m_inner_prod #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c),
        .busy(busy), .done(done), .acc_out(acc_out)
    );

    // Polynomial-basis product modulo f = x^67 + x^5 + x^2 + x + 1.
    function automatic logic [W-1:0] gfmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] p;
        logic [2*W-2:0] f;
        p = '0;
        f = '0;
        f[W] = 1'b1; f[5] = 1'b1; f[2] = 1'b1; f[1] = 1'b1; f[0] = 1'b1;
        for (int i = 0; i < int'(W); i++)
            if (b[i]) p = p ^ ({{(W-1){1'b0}}, a} << i);
        for (int i = 2*W-2; i >= int'(W); i--)
            if (p[i]) p = p ^ (f << (i - int'(W)));
        return p[W-1:0];
    endfunction

    // Multiplier stub: captures operands on mul_start, pulses mul_done stub_lat+1 edges later.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (rst) st_dirty <= 1'b1;
        if (mul_start) begin
            st_cnt   <= stub_lat;
            st_a     <= mul_a;
            st_b     <= mul_b;
            st_dirty <= 1'b0;
            stub_c   <= use_gf ? gfmul(mul_a, mul_b) : (mul_a ^ mul_b);
            n_mstart <= n_mstart + 1;
        end else if (st_cnt != 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) begin
                stub_done <= 1'b1;
                n_sdone   <= n_sdone + 1;
                if (!st_dirty && (mul_a !== st_a || mul_b !== st_b)) stab_bad <= stab_bad + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int n);
        if (n == 0) return 1;
`ifdef GF2M_IP_PREFETCH_EN
        return 7 * n + 2;
`else
        return 8 * n + 1;
`endif
    endfunction

    // One inner product over pa/pb[0..n-1]; returns final acc, start-to-done cycles and mul_start count.
    task automatic run_seq(input int n, input int gap, input bit rnd_gap, input bit do_inj,
                           input int mid_at, output logic [W-1:0] acc, output int lat, output int nst);
        int base;
        base = n_mstart;
        fork
            begin
                len   = LW'(n);
                start = 1'b1;
                tick;
                start = 1'b0;
                lat   = 1;
                check("busy_after_start", busy, 1);
                while (!done && lat < 5000) begin
                    if (lat == mid_at) begin
                        start = 1'b1;
                        len   = LW'(n + 3);
                    end else begin
                        start = 1'b0;
                    end
                    tick;
                    lat++;
                end
                start = 1'b0;
                if (!done) check("done_timeout", done, 1);
                acc = acc_out;
            end
            begin
                int  budget;
                bit  injected;
                logic hs;
                budget   = 0;
                injected = 1'b0;
                for (int i = 0; i < n; i++) begin
                    int g;
                    g = rnd_gap ? int'($urandom_range(0, gap)) : gap;
                    in_valid = 1'b0;
                    for (int j = 0; j < g; j++) begin
                        if (do_inj && !injected && busy && !mul_start && !stub_done && st_cnt == 0) begin
                            inj      = 1'b1;
                            inj_c    = W'(67'h5A5A_0F0F);
                            injected = 1'b1;
                        end
                        tick;
                        inj = 1'b0;
                    end
                    in_valid = 1'b1;
                    in_a     = pa[i];
                    in_b     = pb[i];
                    do begin
                        hs = in_ready;
                        tick;
                        budget++;
                    end while (!hs && budget < 5000);
                    in_valid = 1'b0;
                    if (!hs) check("handshake_timeout", hs, 1);
                end
            end
        join
        nst = n_mstart - base;
    endtask

    typedef struct {
        int                    n;
        logic [3:0][W-1:0]     a;
        logic [3:0][W-1:0]     b;
        int                    gap;
        int                    mid_at;
        logic [W-1:0]          exp_acc;
        string                 name;
    } vec_t;

    vec_t         vt[6];
    logic [W-1:0] acc;
    logic [W-1:0] ref_acc;
    int           lat;
    int           nst;
    int           base;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fixed vectors.
        for (int k = 0; k < 6; k++) begin
            vt[k].a = '0; vt[k].b = '0; vt[k].gap = 0; vt[k].mid_at = -1;
        end
        vt[0].name = "three_pairs"; vt[0].n = 3;
        vt[0].a[0] = W'(1); vt[0].b[0] = W'(4);
        vt[0].a[1] = W'(2); vt[0].b[1] = W'(8);
        vt[0].a[2] = W'(16); vt[0].b[2] = W'(16);
        vt[0].exp_acc = W'(15);
        vt[1].name = "len_zero"; vt[1].n = 0; vt[1].exp_acc = '0;
        vt[2].name = "one_pair"; vt[2].n = 1;
        vt[2].a[0] = W'(5); vt[2].b[0] = W'(3); vt[2].exp_acc = W'(6);
        vt[3] = vt[0]; vt[3].name = "backpressure"; vt[3].gap = 10;
        vt[4] = vt[0]; vt[4].name = "start_while_busy"; vt[4].mid_at = 10;
        vt[5].name = "four_edges"; vt[5].n = 4;
        vt[5].a[0] = {W{1'b1}};                 vt[5].b[0] = '0;
        vt[5].a[1] = {1'b1, {(W-1){1'b0}}};    vt[5].b[1] = W'(1);
        vt[5].a[2] = W'(12'hAAA);              vt[5].b[2] = W'(12'h555);
        vt[5].a[3] = W'(67'h1234_5678_9ABC);   vt[5].b[3] = W'(67'h1234_5678_9ABC);
        vt[5].exp_acc = {1'b0, {54{1'b1}}, 11'b0, 1'b1};

        // Reset state.
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a", mul_a, '0);
        check("rst_mul_b", mul_b, '0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_acc", acc_out, '0);
        check("gf_model_x67", gfmul({1'b1, {(W-1){1'b0}}}, W'(2)), W'(67'h27));

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                pa[i] = vt[k].a[i];
                pb[i] = vt[k].b[i];
            end
            run_seq(vt[k].n, vt[k].gap, 1'b0, vt[k].gap > 0, vt[k].mid_at, acc, lat, nst);
            check({vt[k].name, "_acc"}, acc, vt[k].exp_acc);
            check_int({vt[k].name, "_mul_starts"}, nst, vt[k].n);
            if (vt[k].gap == 0 && vt[k].mid_at < 0)
                check_int({vt[k].name, "_latency"}, lat, exp_latency(vt[k].n));
            tick;
            check({vt[k].name, "_done_single"}, done, 0);
            check({vt[k].name, "_idle_after"}, busy, 0);
            repeat (3) tick;
        end

        // Reset during WAIT of the second pair.
        base = n_mstart;
        in_valid = 1'b1; in_a = W'(7); in_b = W'(9);
        len = LW'(3); start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 100 && (n_mstart - base) < 2; i++) tick;
        check_int("rst_mid_reached_pair2", n_mstart - base, 2);
        tick; tick;
        rst = 1'b1; tick; rst = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 0);
        check("rst_mid_mul_start", mul_start, 0);
        check("rst_mid_mul_a", mul_a, '0);
        check("rst_mid_mul_b", mul_b, '0);
        check("rst_mid_done", done, 0);
        check("rst_mid_acc", acc_out, '0);
        repeat (10) tick;
        check("stale_done_acc", acc_out, '0);
        check("stale_done_busy", busy, 0);
        pa[0] = W'(3); pb[0] = W'(3);
        run_seq(1, 0, 1'b0, 1'b0, -1, acc, lat, nst);
        check("after_rst_acc", acc, '0);
        check_int("after_rst_latency", lat, exp_latency(1));
        repeat (2) tick;

        // Random streams against an XOR-sum reference.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            ref_acc = '0;
            for (int i = 0; i < n; i++) begin
                pa[i] = W'({$urandom(), $urandom(), $urandom()});
                pb[i] = W'({$urandom(), $urandom(), $urandom()});
                ref_acc = ref_acc ^ pa[i] ^ pb[i];
            end
            run_seq(n, 4, 1'b1, 1'b1, -1, acc, lat, nst);
            check("rand_acc", acc, ref_acc);
            check_int("rand_mul_starts", nst, n);
            repeat (2) tick;
        end

        // Maximum length: counter must reach 255 without wrapping.
        ref_acc = '0;
        for (int i = 0; i < 255; i++) begin
            pa[i] = W'({$urandom(), $urandom(), $urandom()});
            pb[i] = W'({$urandom(), $urandom(), $urandom()});
            ref_acc = ref_acc ^ pa[i] ^ pb[i];
        end
        run_seq(255, 0, 1'b0, 1'b0, -1, acc, lat, nst);
        check("max_len_acc", acc, ref_acc);
        check_int("max_len_mul_starts", nst, 255);
        check_int("max_len_latency", lat, exp_latency(255));
        repeat (2) tick;

        // True GF(2^67) products: 16 random pairs.
        use_gf   = 1'b1;
        stub_lat = 7;
        ref_acc  = '0;
        for (int i = 0; i < 16; i++) begin
            pa[i] = W'({$urandom(), $urandom(), $urandom()});
            pb[i] = W'({$urandom(), $urandom(), $urandom()});
            ref_acc = ref_acc ^ gfmul(pa[i], pb[i]);
        end
        run_seq(16, 2, 1'b1, 1'b0, -1, acc, lat, nst);
        check("gf_inner_product", acc, ref_acc);
        check_int("gf_mul_starts", nst, 16);
        repeat (3) tick;

        check_int("operand_stable", stab_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
